// File: rtl/pc_seq_if.sv
// pc_seq_if -- bus between the control unit and the PC sequencer.
//   master : control side. Drives pc_we, pc_src, imm_ext, j_addr, reg_rs,
//            ras_push and ras_pop. Observes the sequencer outputs.
//   slave  : pc_seq_unit. Drives current_pc, next_pc, ras_top, ras_empty,
//            ras_full, ras_overflow, ras_underflow, misalign_trap and epc.
interface pc_seq_if #(
  parameter int unsigned XLEN = 32
);
  logic            pc_we;
  logic [2:0]      pc_src;
  logic [XLEN-1:0] imm_ext;
  logic [25:0]     j_addr;
  logic [XLEN-1:0] reg_rs;
  logic            ras_push;
  logic            ras_pop;
  logic [XLEN-1:0] current_pc;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty;
  logic            ras_full;
  logic            ras_overflow;
  logic            ras_underflow;
  logic            misalign_trap;
  logic [XLEN-1:0] epc;

  modport master (
    output pc_we, pc_src, imm_ext, j_addr, reg_rs, ras_push, ras_pop,
    input  current_pc, next_pc, ras_top, ras_empty, ras_full,
           ras_overflow, ras_underflow, misalign_trap, epc
  );

  modport slave (
    input  pc_we, pc_src, imm_ext, j_addr, reg_rs, ras_push, ras_pop,
    output current_pc, next_pc, ras_top, ras_empty, ras_full,
           ras_overflow, ras_underflow, misalign_trap, epc
  );
endinterface

// File: rtl/pc_seq_unit.sv
// pc_seq_unit -- program-counter sequencer with a return-address stack.
// The unit holds the architectural PC. It selects the next fetch address from
// six sources and keeps a circular RAS for call and return linking.
// Ports:
//   CLK : clock. All state updates happen on the falling edge.
//   RST : asynchronous, active-low reset.
//   bus : pc_seq_if.slave, which carries the control inputs and the PC, RAS and
//         trap outputs.
// Optional feature: define PC_ALIGN_CHECK_EN to trap on a misaligned next_pc.
// On a trap, current_pc is loaded with TRAP_VECTOR and epc records the target.
// When the macro is undefined, the low two bits of the target are dropped.
module pc_seq_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     RAS_DEPTH    = 4,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0080)
) (
  input  logic CLK,
  input  logic RST,
  pc_seq_if.slave bus
);
  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] ras_top;
  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   top_q;
  logic [PW-1:0]   top_inc;
  logic [CW-1:0]   cnt_q;
  logic            ovf_q;
  logic            unf_q;
  logic            empty;
  logic            full;
  logic            trap_now;

  assign pc4     = pc_q + XLEN'(4);
  assign top_inc = top_q + 1'b1;
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == DEPTH_C);
  assign ras_top = empty ? RESET_VECTOR : ras_mem[top_q];

  always_comb begin
    next_pc = pc4;
    unique case (bus.pc_src)
      3'b000:  next_pc = pc4;
      3'b001:  next_pc = pc4 + {bus.imm_ext[XLEN-3:0], 2'b00};
      3'b010:  next_pc = bus.reg_rs;
      3'b011:  next_pc = {pc4[XLEN-1:28], bus.j_addr, 2'b00};
      3'b100:  next_pc = ras_top;
      3'b101:  next_pc = RESET_VECTOR;
      default: next_pc = pc4;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  logic            trap_q;
  logic [XLEN-1:0] epc_q;

  assign trap_now = bus.pc_we && (next_pc[1:0] != 2'b00);

  // A trap raises the pulse for one period. A trap on the following edge can
  // re-raise it.
  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      trap_q <= 1'b0;
      epc_q  <= '0;
    end else begin
      trap_q <= trap_now;
      if (trap_now) epc_q <= next_pc;
    end
  end

  assign bus.misalign_trap = trap_q;
  assign bus.epc           = epc_q;
`else
  assign trap_now          = 1'b0;
  assign bus.misalign_trap = 1'b0;
  assign bus.epc           = '0;
`endif

  // A push writes above top, so a full stack overwrites its oldest slot and
  // the pointer wraps. A push and pop on the same edge replace the top entry.
  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      pc_q  <= RESET_VECTOR;
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else if (bus.pc_we) begin
      if (trap_now) begin
        pc_q <= TRAP_VECTOR;
      end else begin
        pc_q <= {next_pc[XLEN-1:2], 2'b00};
        if (bus.ras_push && bus.ras_pop && !empty) begin
          ras_mem[top_q] <= pc4;
        end else if (bus.ras_push) begin
          top_q            <= top_inc;
          ras_mem[top_inc] <= pc4;
          if (full) ovf_q <= 1'b1;
          else      cnt_q <= cnt_q + 1'b1;
        end else if (bus.ras_pop) begin
          if (empty) begin
            unf_q <= 1'b1;
          end else begin
            top_q <= top_q - 1'b1;
            cnt_q <= cnt_q - 1'b1;
          end
        end
      end
    end
  end

  assign bus.current_pc    = pc_q;
  assign bus.next_pc       = next_pc;
  assign bus.ras_top       = ras_top;
  assign bus.ras_empty     = empty;
  assign bus.ras_full      = full;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;
endmodule

// File: tb/tb_pc_seq_unit.sv
// tb_pc_seq_unit -- directed bench for pc_seq_unit (XLEN=32, RAS_DEPTH=4).
// The reference model keeps the RAS as a queue of link addresses. It is
// compared with the DUT on every rising edge, and literal checks pin the
// directed scenarios.
module tb_pc_seq_unit;
  localparam logic [31:0] RV    = 32'h0;
  localparam logic [31:0] TV    = 32'h80;
  localparam int          DEPTH = 4;

  logic CLK = 1'b1;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  pc_seq_if #(.XLEN(32)) bus ();

  pc_seq_unit #(
    .XLEN(32), .RESET_VECTOR(RV), .RAS_DEPTH(DEPTH), .TRAP_VECTOR(TV)
  ) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model
  logic [31:0] m_pc, m_epc;
  logic        m_trap, m_ovf, m_unf;
  logic [31:0] m_q[$];
  logic [31:0] np, lnk;
  bit          bad;

  function automatic logic [31:0] m_top();
    return (m_q.size() == 0) ? RV : m_q[m_q.size()-1];
  endfunction

  function automatic logic [31:0] m_next();
    logic [31:0] p4;
    p4 = m_pc + 32'd4;
    case (bus.pc_src)
      3'b001:  return p4 + (bus.imm_ext * 4);
      3'b010:  return bus.reg_rs;
      3'b011:  return {p4[31:28], bus.j_addr, 2'b00};
      3'b100:  return m_top();
      3'b101:  return RV;
      default: return p4;
    endcase
  endfunction

  always @(negedge CLK or negedge RST) begin
    if (!RST) begin
      m_pc = RV; m_epc = 32'h0; m_trap = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      m_q.delete();
    end else begin
      m_trap = 1'b0;
      if (bus.pc_we) begin
        np  = m_next();
        lnk = m_pc + 32'd4;
        bad = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        bad = (np[1:0] != 2'b00);
`endif
        if (bad) begin
          m_pc = TV; m_epc = np; m_trap = 1'b1;
        end else begin
          m_pc = {np[31:2], 2'b00};
          if (bus.ras_push && bus.ras_pop && m_q.size() > 0) begin
            m_q[m_q.size()-1] = lnk;
          end else if (bus.ras_push) begin
            if (m_q.size() == DEPTH) begin
              void'(m_q.pop_front());
              m_ovf = 1'b1;
            end
            m_q.push_back(lnk);
          end else if (bus.ras_pop) begin
            if (m_q.size() == 0) m_unf = 1'b1;
            else void'(m_q.pop_back());
          end
        end
      end
    end
  end

  // Every-cycle comparison on the edge opposite the active one
  always @(posedge CLK) begin
    if (chk_en) begin
      chk("cmp.current_pc", bus.current_pc, m_pc);
      chk("cmp.next_pc", bus.next_pc, m_next());
      chk("cmp.ras_top", bus.ras_top, m_top());
      chk("cmp.ras_empty", bus.ras_empty, m_q.size() == 0);
      chk("cmp.ras_full", bus.ras_full, m_q.size() == DEPTH);
      chk("cmp.ras_overflow", bus.ras_overflow, m_ovf);
      chk("cmp.ras_underflow", bus.ras_underflow, m_unf);
      chk("cmp.misalign_trap", bus.misalign_trap, m_trap);
      chk("cmp.epc", bus.epc, m_epc);
    end
  end

  // Drive one edge's inputs, then sample just after the falling edge
  task automatic step(input logic we, input logic [2:0] src, input logic [31:0] rs,
                      input logic [31:0] imm, input logic [25:0] j,
                      input logic push, input logic pop);
    bus.pc_we = we; bus.pc_src = src; bus.reg_rs = rs; bus.imm_ext = imm;
    bus.j_addr = j; bus.ras_push = push; bus.ras_pop = pop;
    @(negedge CLK);
    #1;
  endtask

  initial begin
    bus.pc_we = 1'b0; bus.pc_src = 3'b000; bus.imm_ext = '0; bus.j_addr = '0;
    bus.reg_rs = '0; bus.ras_push = 1'b0; bus.ras_pop = 1'b0;
    #1 RST = 1'b0;
    #1;
    chk("reset.current_pc", bus.current_pc, 32'h0);
    chk("reset.ras_empty", bus.ras_empty, 1'b1);
    chk("reset.ras_full", bus.ras_full, 1'b0);
    chk("reset.trap", bus.misalign_trap, 1'b0);
    chk_en = 1'b1;
    #5 RST = 1'b1;

    // Sequential fetch
    step(1, 3'b000, 0, 0, 0, 0, 0); chk("seq.pc1", bus.current_pc, 32'h4);
    step(1, 3'b000, 0, 0, 0, 0, 0); chk("seq.pc2", bus.current_pc, 32'h8);
    step(1, 3'b000, 0, 0, 0, 0, 0); chk("seq.pc3", bus.current_pc, 32'hC);

    // Asynchronous reset in the middle of a cycle
    #2 RST = 1'b0;
    #1 chk("midreset.current_pc", bus.current_pc, 32'h0);
    @(posedge CLK); #1 RST = 1'b1;

    // Branch and jump targets, combinational
    step(1, 3'b010, 32'h100, 0, 0, 0, 0); chk("jr.pc", bus.current_pc, 32'h100);
    bus.pc_we = 1'b0; bus.pc_src = 3'b001; bus.imm_ext = 32'hFFFF_FFFE;
    #1 chk("branch.next_pc", bus.next_pc, 32'hFC);
    bus.pc_src = 3'b011; bus.j_addr = 26'h0000040;
    #1 chk("jump.next_pc", bus.next_pc, 32'h100);

    // RAS overflow and pop sequence
    RST = 1'b0; #1 RST = 1'b1;
    step(1, 3'b010, 32'h10, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) step(1, 3'b010, 32'h10 * (k + 1), 0, 0, 1, 0);
    chk("ovf.ras_full", bus.ras_full, 1'b1);
    chk("ovf.ras_overflow", bus.ras_overflow, 1'b1);
    chk("ovf.ras_top", bus.ras_top, 32'h54);
    step(1, 3'b100, 0, 0, 0, 0, 1); chk("pop.pc1", bus.current_pc, 32'h54);
    step(1, 3'b100, 0, 0, 0, 0, 1); chk("pop.pc2", bus.current_pc, 32'h44);
    step(1, 3'b100, 0, 0, 0, 0, 1); chk("pop.pc3", bus.current_pc, 32'h34);
    step(1, 3'b100, 0, 0, 0, 0, 1); chk("pop.pc4", bus.current_pc, 32'h24);
    chk("pop.ras_empty", bus.ras_empty, 1'b1);

    // Underflow, then push+pop replacing the top entry
    step(1, 3'b000, 0, 0, 0, 0, 1);
    chk("unf.ras_underflow", bus.ras_underflow, 1'b1);
    chk("unf.ras_top", bus.ras_top, RV);
    chk("unf.current_pc", bus.current_pc, 32'h28);
    step(1, 3'b000, 0, 0, 0, 1, 0);
    step(1, 3'b000, 0, 0, 0, 1, 0);
    step(1, 3'b010, 32'h200, 0, 0, 0, 0);
    step(1, 3'b000, 0, 0, 0, 1, 1);
    chk("pushpop.ras_top", bus.ras_top, 32'h204);
    chk("pushpop.ras_full", bus.ras_full, 1'b0);
    step(1, 3'b100, 0, 0, 0, 0, 1); chk("pushpop.pc1", bus.current_pc, 32'h204);
    chk("pushpop.not_empty", bus.ras_empty, 1'b0);
    step(1, 3'b100, 0, 0, 0, 0, 1); chk("pushpop.pc2", bus.current_pc, 32'h2C);
    chk("pushpop.empty", bus.ras_empty, 1'b1);

    // Misaligned register target
    step(1, 3'b010, 32'h1002, 0, 0, 0, 0);
`ifdef PC_ALIGN_CHECK_EN
    chk("trap.current_pc", bus.current_pc, 32'h80);
    chk("trap.epc", bus.epc, 32'h1002);
    chk("trap.pulse", bus.misalign_trap, 1'b1);
    step(1, 3'b000, 0, 0, 0, 0, 0);
    chk("trap.pulse_end", bus.misalign_trap, 1'b0);
    chk("trap.after_pc", bus.current_pc, 32'h84);
    step(0, 3'b001, 0, 32'h5, 0, 1, 0);
    chk("hold.current_pc", bus.current_pc, 32'h84);
`else
    chk("align.current_pc", bus.current_pc, 32'h1000);
    chk("align.no_trap", bus.misalign_trap, 1'b0);
    step(1, 3'b000, 0, 0, 0, 0, 0);
    chk("align.after_pc", bus.current_pc, 32'h1004);
    step(0, 3'b001, 0, 32'h5, 0, 1, 0);
    chk("hold.current_pc", bus.current_pc, 32'h1004);
`endif
    chk("hold.ras_empty", bus.ras_empty, 1'b1);
    step(0, 3'b000, 0, 0, 0, 0, 0);
    @(posedge CLK); #1;
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_seq_unit.md
# pc_seq_unit

Parametrised program-counter sequencer for the multi-cycle CPU datapath, the successor to the plain PC register. Holds the architectural PC, computes the next fetch address from six sources, and keeps a hardware return-address stack (RAS) for call/return prediction-free linking. Sits between the control unit (PC write enable, source select, push/pop) and instruction memory (current_pc).

## Interface
- XLEN, 32: address width; legal values 32 or 64.
- RESET_VECTOR, 0: value of current_pc after reset and for pc_src=101.
- RAS_DEPTH, 4: RAS entries; power of two, ≥2.
- TRAP_VECTOR, 32'h0000_0080 (zero-extended to XLEN): misalignment trap target (used only with PC_ALIGN_CHECK_EN).

Ports:
- CLK  in  1  clock; all state updates on the falling edge.
- RST  in  1  reset, asynchronous, active-low.
- pc_we  in  1  PC write enable; also qualifies ras_push/ras_pop.
- pc_src  in  3  next-PC source select.
- imm_ext  in  XLEN  sign-extended branch offset, in words.
- j_addr  in  26  jump target field.
- reg_rs  in  XLEN  register operand for jump-register.
- ras_push  in  1  push link address (current_pc+4).
- ras_pop  in  1  pop top entry.
- current_pc  out  XLEN  registered PC.
- next_pc  out  XLEN  combinational next PC.
- ras_top  out  XLEN  top RAS entry (RESET_VECTOR when empty).
- ras_empty, ras_full  out  1  occupancy flags.
- ras_overflow, ras_underflow  out  1  sticky error flags.
- misalign_trap  out  1  trap pulse.
- epc  out  XLEN  faulting next_pc of last trap.

## Operation
- pc4 = current_pc + 4, modulo 2^XLEN.
- next_pc by pc_src, fully combinational on all inputs: 000 pc4; 001 pc4 + (imm_ext << 2); 010 reg_rs; 011 {pc4[XLEN-1:28], j_addr, 2'b00}; 100 ras_top; 101 RESET_VECTOR; 110/111 pc4.
- Falling edge with pc_we=1: current_pc ← next_pc (subject to Configuration). pc_we=0: PC and RAS hold; push/pop ignored.
- RAS: circular buffer, pointer top, count 0..RAS_DEPTH. ras_empty = (count==0), ras_full = (count==RAS_DEPTH).
- Push only: write pc4 at top+1, count+1. When full: oldest entry overwritten (pointer wraps), count stays RAS_DEPTH, ras_overflow←1.
- Pop only: top−1, count−1. When empty: no state change, ras_underflow←1.
- Push+pop same edge: count>0 → top entry replaced by pc4, count unchanged; count==0 → plain push, no underflow.
- pc_src=100 uses ras_top as it stands before that edge's pop.
- Sticky flags clear only on reset.

## Timing
- Reset (RST low, any time, including mid-sequence): current_pc=RESET_VECTOR, count=0, top=0, all entries 0, ras_empty=1, ras_full=0, ras_overflow=ras_underflow=0, misalign_trap=0, epc=0. Takes effect immediately, not clock-aligned.
- next_pc valid combinationally within the same cycle as its inputs; zero-cycle latency.
- current_pc, RAS state, flags update one falling edge after pc_we sampled high.
- misalign_trap is registered: high for exactly one clock period following the trapping edge.

## Configuration
- PC_ALIGN_CHECK_EN defined: at a pc_we edge with next_pc[1:0]≠0, current_pc←TRAP_VECTOR, epc←next_pc, misalign_trap=1 for one cycle; RAS push/pop on that edge suppressed.
- Undefined: current_pc←{next_pc[XLEN-1:2],2'b00}; misalign_trap and epc tied to 0.

## Test plan
- Reset, then 3 edges pc_we=1, pc_src=000 -> current_pc 0,4,8,12; assert RST low mid-cycle -> current_pc=0 immediately.
- current_pc=0x100, pc_src=001, imm_ext=−2 -> next_pc=0xFC; pc_src=011, j_addr=0x0000040 -> next_pc=0x100.
- RAS_DEPTH=4: 5 pushes from PCs 0x10,0x20,0x30,0x40,0x50 -> ras_full=1, ras_overflow=1, ras_top=0x54; 4 pops with pc_src=100 -> PC 0x54,0x44,0x34,0x24, ras_empty=1.
- Pop while empty -> ras_underflow=1, ras_top=RESET_VECTOR; push+pop with count=2 at PC 0x200 -> count stays 2, ras_top=0x204.
- With PC_ALIGN_CHECK_EN: pc_src=010, reg_rs=0x1002 -> current_pc=0x80, epc=0x1002, misalign_trap one cycle; without -> current_pc=0x1000.
- pc_we=0 with ras_push=1, pc_src=001 -> current_pc and RAS unchanged.
